// File: rtl/sync_timing_gen_pkg.sv
// sync_timing_gen_pkg: shared video timing constants and window helper for the sync generator.
package sync_timing_gen_pkg;

    localparam int POS_W        = 9;
    localparam int PAL_H_TOTAL  = 228;
    localparam int PAL_V_TOTAL  = 312;
    localparam int PAL_FS_LINES = 32;
    localparam int NTSC_H_TOTAL = 228;
    localparam int NTSC_V_TOTAL = 262;

    // One extra bit keeps lo+len from overflowing when the window ends at 512.
    function automatic logic in_window(input logic [POS_W-1:0] v, input logic [POS_W:0] lo, input logic [POS_W:0] len);
        return ({1'b0, v} >= lo) && ({1'b0, v} < lo + len);
    endfunction

endpackage

// File: rtl/tc_counter.sv
// tc_counter: mod-N up-counter with clock enable, async reset and terminal-count flag.
module tc_counter #(
    parameter int N = 228,
    parameter int W = 9
) (
    input  logic         cp,
    input  logic         mr,
    input  logic         ce,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt,
    output logic         tc
);

    assign tc  = q == W'(N - 1);
    assign nxt = ce ? (tc ? '0 : q + 1'b1) : q;

    always_ff @(posedge cp or posedge mr)
        if (mr) q <= '0;
        else    q <= nxt;

endmodule

// File: rtl/sync_timing_gen.sv
// sync_timing_gen: active-low hsync/field-sync strobes, beam position and display enable.
// All strobes are registered from the next beam position so they line up with x/y.
module sync_timing_gen
    import sync_timing_gen_pkg::*;
#(
    parameter int H_TOTAL        = PAL_H_TOTAL,
    parameter int H_SYNC         = 17,
    parameter int H_ACTIVE_START = 40,
    parameter int H_ACTIVE_LEN   = 128,
    parameter int V_TOTAL        = PAL_V_TOTAL,
    parameter int V_ACTIVE_START = 38,
    parameter int V_ACTIVE_LEN   = 192,
    parameter int FS_LINES       = PAL_FS_LINES
) (
    input  logic             cp,
    input  logic             mr,
    input  logic             ce,
    output logic             hsb,
    output logic             fsb,
    output logic             de,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             sof
);

    localparam logic [POS_W-1:0] HS   = POS_W'(H_SYNC);
    localparam logic [POS_W-1:0] FS0  = POS_W'(V_TOTAL - FS_LINES);
    localparam logic [POS_W:0]   HA0  = (POS_W+1)'(H_ACTIVE_START);
    localparam logic [POS_W:0]   HAL  = (POS_W+1)'(H_ACTIVE_LEN);
    localparam logic [POS_W:0]   VA0  = (POS_W+1)'(V_ACTIVE_START);
    localparam logic [POS_W:0]   VAL  = (POS_W+1)'(V_ACTIVE_LEN);

    if (!(H_TOTAL <= 512 && H_SYNC < H_ACTIVE_START && H_ACTIVE_START + H_ACTIVE_LEN <= H_TOTAL &&
          V_ACTIVE_START + V_ACTIVE_LEN <= V_TOTAL - FS_LINES && FS_LINES >= 25)) begin : g_bad_params
        $fatal(1, "sync_timing_gen: inconsistent timing parameters");
    end

    logic             primed, run, x_tc, y_tc;
    logic [POS_W-1:0] nx, ny;

    // The first enabled edge after reset presents (0,0) without advancing the counters.
    assign run = ce & ~primed;

    tc_counter #(.N(H_TOTAL), .W(POS_W)) u_x (
        .cp(cp), .mr(mr), .ce(run), .q(x), .nxt(nx), .tc(x_tc)
    );

    tc_counter #(.N(V_TOTAL), .W(POS_W)) u_y (
        .cp(cp), .mr(mr), .ce(run & x_tc), .q(y), .nxt(ny), .tc(y_tc)
    );

    always_ff @(posedge cp or posedge mr)
        if (mr) begin
            primed <= 1'b1;
            hsb    <= 1'b1;
            fsb    <= 1'b1;
            de     <= 1'b0;
            sof    <= 1'b0;
        end else if (ce) begin
            primed <= 1'b0;
            hsb    <= nx >= HS;
            fsb    <= (nx == '0) ? ny < FS0 : fsb;
            de     <= in_window(nx, HA0, HAL) && in_window(ny, VA0, VAL);
            sof    <= primed | (x_tc & y_tc);
        end

endmodule

// File: tb/tb_sync_timing_gen.sv
// tb_sync_timing_gen: randomized-ce bench for sync_timing_gen against a beam-index reference model.
module tb_sync_timing_gen;

    localparam int HT = 228, VT = 312, HSW = 17, FSL = 32;
    localparam int HA0 = 40, HAL = 128, VA0 = 38, VAL = 192;

    logic       cp = 0, mr = 0, ce = 0;
    logic       hsb, fsb, de, sof;
    logic [8:0] x, y;

    int checks = 0, errors = 0;
    bit m_valid = 0;
    int m_k = 0;

    sync_timing_gen dut (
        .cp(cp), .mr(mr), .ce(ce), .hsb(hsb), .fsb(fsb), .de(de), .x(x), .y(y), .sof(sof)
    );

    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, m_k);
        end
    endtask

    // Expected outputs derived from the number of enabled edges since release.
    task automatic check_all();
        int ex, ey;
        ex = m_valid ? m_k % HT : 0;
        ey = m_valid ? (m_k / HT) % VT : 0;
        chk("x", {23'd0, x}, ex);
        chk("y", {23'd0, y}, ey);
        chk("hsb", {31'd0, hsb}, (m_valid && ex < HSW) ? 0 : 1);
        chk("fsb", {31'd0, fsb}, (m_valid && ey >= VT - FSL) ? 0 : 1);
        chk("de", {31'd0, de}, (m_valid && ex >= HA0 && ex < HA0 + HAL && ey >= VA0 && ey < VA0 + VAL) ? 1 : 0);
        chk("sof", {31'd0, sof}, (m_valid && ex == 0 && ey == 0) ? 1 : 0);
    endtask

    task automatic tick(input logic c);
        ce = c;
        @(posedge cp);
        if (c && !mr) begin
            if (!m_valid) begin
                m_valid = 1;
                m_k = 0;
            end else m_k++;
        end
        @(negedge cp);
        check_all();
    endtask

    initial begin
        int sofs, hcnt, det, dety;
        logic ph;
        #1 mr = 1;
        #2 check_all();
        repeat (3) tick(1);
        mr = 0;
        tick(1);
        chk("first_x", {23'd0, x}, 0);
        chk("first_sof", {31'd0, sof}, 1);
        chk("first_hsb", {31'd0, hsb}, 0);
        repeat (3000) tick(1'($urandom_range(0, 1)));
        sofs = 0; hcnt = 0; det = 0; dety = -1; ph = 1;
        for (int i = 0; i < HT * VT + HT; i++) begin
            tick(1);
            if (i < HT * VT && sof) sofs++;
            if (!fsb && ph && !hsb) begin
                hcnt++;
                if (hcnt == 24) begin
                    det++;
                    dety = int'(y);
                end
            end
            if (fsb) hcnt = 0;
            ph = hsb;
        end
        chk("sof_per_field", sofs, 1);
        chk("hs24_count", det, 1);
        chk("hs24_line", dety, VT - FSL + 23);
        repeat (1000) tick(0);
        for (int i = 0; i < 300 && (m_k % HT) != 100; i++) tick(1);
        chk("reach_x100", {23'd0, x}, 100);
        #1 mr = 1;
        m_valid = 0;
        #1 check_all();
        repeat (5) tick(1'($urandom_range(0, 1)));
        mr = 0;
        tick(0);
        tick(1);
        chk("rerelease_sof", {31'd0, sof}, 1);
        repeat (500) tick(1'($urandom_range(0, 1)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
